// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data/instruction cache.
// Addresses are 30-bit word addresses laid out as {tag, index, word offset}.
package dcache_pkg;

  localparam int ADDR_W = 30;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    ALLOC = 2'd2
  } state_t;

  function automatic logic [ADDR_W-1:0] tag_of(input logic [ADDR_W-1:0] addr,
                                                input int index_w, input int ofs_w);
    return addr >> (index_w + ofs_w);
  endfunction

  function automatic logic [ADDR_W-1:0] idx_of(input logic [ADDR_W-1:0] addr,
                                                input int index_w, input int ofs_w);
    return (addr >> ofs_w) & ((ADDR_W'(1) << index_w) - ADDR_W'(1));
  endfunction

  function automatic logic [ADDR_W-1:0] ofs_of(input logic [ADDR_W-1:0] addr,
                                                input int ofs_w);
    return addr & ((ADDR_W'(1) << ofs_w) - ADDR_W'(1));
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Line storage: valid/dirty/tag/data per line, one lookup port and one write port
// (single-word store or full-line fill). Only valid/dirty are reset.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W    = 3,
  parameter int WORD_OFS_W = 2,
  parameter int TAG_W      = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    idx,
  output logic                  line_valid,
  output logic                  line_dirty,
  output logic [TAG_W-1:0]      line_tag,
  output logic [LINE_W-1:0]     line_data,
  input  logic                  word_we,
  input  logic [WORD_OFS_W-1:0] word_ofs,
  input  logic [WORD_W-1:0]     word_data,
  input  logic                  fill_we,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [LINE_W-1:0]     fill_data
);

  localparam int NUM_LINES = 2 ** INDEX_W;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (word_we) begin
      data_q[idx][word_ofs*WORD_W +: WORD_W] <= word_data;
    end
  end

  assign line_valid = valid_q[idx];
  assign line_dirty = dirty_q[idx];
  assign line_tag   = tag_q[idx];
  assign line_data  = data_q[idx];

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back/write-allocate cache: zero-stall hits, miss FSM that
// writes back a dirty victim and then fills the line over a 128-bit memory bus.
module dcache_direct_mapped
  import dcache_pkg::*;
#(
  parameter int INDEX_W    = 3,
  parameter int WORD_OFS_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                proc_read,
  input  logic                proc_write,
  input  logic [ADDR_W-1:0]   proc_addr,
  input  logic [WORD_W-1:0]   proc_wdata,
  output logic                proc_stall,
  output logic [WORD_W-1:0]   proc_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [27:0]         mem_addr,
  output logic [LINE_W-1:0]   mem_wdata,
  input  logic [LINE_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  localparam int TAG_W = ADDR_W - INDEX_W - WORD_OFS_W;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]     tag_full, idx_full, ofs_full;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    idx;
  logic [WORD_OFS_W-1:0] ofs;
  logic                  line_valid, line_dirty, hit, req;
  logic [TAG_W-1:0]      line_tag;
  logic [LINE_W-1:0]     line_data;
  logic                  word_we, fill_we;

  assign tag_full = tag_of(proc_addr, INDEX_W, WORD_OFS_W);
  assign idx_full = idx_of(proc_addr, INDEX_W, WORD_OFS_W);
  assign ofs_full = ofs_of(proc_addr, WORD_OFS_W);
  assign req_tag  = tag_full[TAG_W-1:0];
  assign idx      = idx_full[INDEX_W-1:0];
  assign ofs      = ofs_full[WORD_OFS_W-1:0];

  // Upper bits of the helper results are zero by construction.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{tag_full[ADDR_W-1:TAG_W], idx_full[ADDR_W-1:INDEX_W],
                              ofs_full[ADDR_W-1:WORD_OFS_W]};

  assign req = proc_read || proc_write;
  assign hit = line_valid && (line_tag == req_tag);

  dcache_line_array #(
    .INDEX_W    (INDEX_W),
    .WORD_OFS_W (WORD_OFS_W),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .line_data  (line_data),
    .word_we    (word_we),
    .word_ofs   (ofs),
    .word_data  (proc_wdata),
    .fill_we    (fill_we),
    .fill_tag   (req_tag),
    .fill_data  (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    word_we    = 1'b0;
    fill_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          proc_stall = 1'b1;
          state_d    = (line_valid && line_dirty) ? WB : ALLOC;
        end else begin
          word_we = proc_write && hit;
          if (proc_read && hit) proc_rdata = line_data[ofs*WORD_W +: WORD_W];
        end
      end
      WB: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {line_tag, idx};
        mem_wdata  = line_data;
        if (mem_ready) state_d = ALLOC;
      end
      ALLOC: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = {req_tag, idx};
        if (mem_ready) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset must release the CPU immediately even while a request is held.
    if (rst) proc_stall = 1'b0;
  end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed bench for dcache_direct_mapped; the bench plays main memory by hand.
module tb_dcache_direct_mapped;

  logic         clk = 1'b0;
  logic         rst;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_direct_mapped dut (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam logic [31:0] WA = 32'h1111_AAAA, WB_ = 32'h2222_BBBB,
                          WC = 32'h3333_CCCC, WD = 32'h4444_DDDD;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    @(negedge clk);
    proc_read = v.rd; proc_write = v.wr; proc_addr = v.addr; proc_wdata = v.wdata;
    #1;
    chk({tag, ".stall"}, 128'(proc_stall), 128'(v.exp_stall));
    chk({tag, ".rdata"}, 128'(proc_rdata), 128'(v.exp_rdata));
    chk({tag, ".memrw"}, 128'({mem_read, mem_write}), 128'(0));
  endtask

  // Miss: request cycle, optional write-back phase, fill phase, then the hit cycle.
  task automatic run_miss(input string tag, input logic rd, input logic wr,
                          input logic [29:0] addr, input logic [31:0] wdata,
                          input bit exp_wb, input logic [27:0] wb_addr,
                          input logic [127:0] wb_data, input int wb_lat,
                          input logic [27:0] al_addr, input int al_lat,
                          input logic [127:0] fill, input logic [31:0] exp_rdata);
    @(negedge clk);
    proc_read = rd; proc_write = wr; proc_addr = addr; proc_wdata = wdata;
    #1;
    chk({tag, ".req_stall"}, 128'(proc_stall), 128'(1));
    chk({tag, ".req_memrw"}, 128'({mem_read, mem_write}), 128'(0));
    if (exp_wb) begin
      for (int i = 0; i < wb_lat; i++) begin
        @(negedge clk);
        mem_ready = (i == wb_lat - 1);
        #1;
        chk({tag, ".wb_rw"}, 128'({mem_read, mem_write, proc_stall}), 128'(3'b011));
        chk({tag, ".wb_addr"}, 128'(mem_addr), 128'(wb_addr));
        chk({tag, ".wb_data"}, mem_wdata, wb_data);
      end
    end
    for (int i = 0; i < al_lat; i++) begin
      @(negedge clk);
      mem_ready = (i == al_lat - 1);
      mem_rdata = fill;
      #1;
      chk({tag, ".al_rw"}, 128'({mem_read, mem_write, proc_stall}), 128'(3'b101));
      chk({tag, ".al_addr"}, 128'(mem_addr), 128'(al_addr));
    end
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    chk({tag, ".hit_stall"}, 128'(proc_stall), 128'(0));
    chk({tag, ".hit_memrw"}, 128'({mem_read, mem_write}), 128'(0));
    chk({tag, ".hit_rdata"}, 128'(proc_rdata), 128'(exp_rdata));
  endtask

  // Protocol monitor: legal CPU requests, exclusive memory strobes, inputs held while stalled.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_in = '0;
  always @(posedge clk) begin
    if (proc_read && proc_write) begin
      errors <= errors + 1;
      $display("FAIL rdwr_both: got 1 expected 0");
    end
    if (mem_read && mem_write) begin
      errors <= errors + 1;
      $display("FAIL mem_both: got 1 expected 0");
    end
    if (!rst && prev_stall && ({proc_read, proc_write, proc_addr, proc_wdata} !== prev_in)) begin
      errors <= errors + 1;
      $display("FAIL stable_in: got %h expected %h",
               {proc_read, proc_write, proc_addr, proc_wdata}, prev_in);
    end
    prev_stall <= proc_stall && !rst;
    prev_in    <= {proc_read, proc_write, proc_addr, proc_wdata};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 30'h11, 32'h0,         1'b0, WB_};
    vecs[1] = '{1'b0, 1'b1, 30'h12, 32'hDEADBEEF,  1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 30'h12, 32'h0,         1'b0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b0, 30'h13, 32'h0,         1'b0, WD};
    vecs[4] = '{1'b1, 1'b0, 30'h10, 32'h0,         1'b0, WA};
    vecs[5] = '{1'b0, 1'b0, 30'h10, 32'h0,         1'b0, 32'h0};

    rst = 1'b0;
    proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    #2 rst = 1'b1;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst.stall", 128'(proc_stall), 128'(0));
    chk("rst.memrw", 128'({mem_read, mem_write}), 128'(0));
    chk("rst.addr", 128'(mem_addr), 128'(0));
    chk("rst.wdata", mem_wdata, 128'(0));
    chk("rst.rdata", 128'(proc_rdata), 128'(0));
    proc_read = 1'b1; proc_addr = 30'h10;
    #1;
    chk("rst.stall_req", 128'(proc_stall), 128'(0));
    @(negedge clk);
    rst = 1'b0; proc_read = 1'b0;

    // 1: clean miss, ready after 3 cycles -> 4 stall cycles
    run_miss("t1", 1'b1, 1'b0, 30'h10, 32'h0, 1'b0, 28'h0, '0, 0,
             28'h4, 3, {WD, WC, WB_, WA}, WA);

    // 2/3: hits from the vector table
    for (int i = 0; i < 6; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

    // 4: conflict miss on a dirty line -> write-back then fill
    run_miss("t4", 1'b1, 1'b0, 30'h92, 32'h0, 1'b1, 28'h4, {WD, 32'hDEADBEEF, WB_, WA}, 2,
             28'h24, 1, 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0, 32'hE2E2E2E2);

    // 5: async reset during ALLOC abandons the fill and clears valid bits
    @(negedge clk);
    proc_read = 1'b1; proc_write = 1'b0; proc_addr = 30'h10;
    #1;
    chk("t5.req_stall", 128'(proc_stall), 128'(1));
    @(negedge clk);
    #1;
    chk("t5.al_read", 128'(mem_read), 128'(1));
    chk("t5.al_addr", 128'(mem_addr), 128'(28'h4));
    #2 rst = 1'b1;
    #1;
    chk("t5.rst_read", 128'(mem_read), 128'(0));
    chk("t5.rst_stall", 128'(proc_stall), 128'(0));
    chk("t5.rst_addr", 128'(mem_addr), 128'(0));
    @(negedge clk);
    rst = 1'b0; proc_read = 1'b0; mem_ready = 1'b1;
    #1;
    chk("t5.idle_stall", 128'(proc_stall), 128'(0));
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("t5.late_ready", 128'({mem_read, mem_write, proc_stall}), 128'(0));
    run_miss("t5b", 1'b1, 1'b0, 30'h92, 32'h0, 1'b0, 28'h0, '0, 0,
             28'h24, 2, 128'h77777777_66666666_55555555_44444444, 32'h66666666);

    // 6: store miss to a clean line allocates without write-back, then merges
    run_miss("t6", 1'b0, 1'b1, 30'h140, 32'h12345678, 1'b0, 28'h0, '0, 0,
             28'h50, 2, 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0, 32'h0);
    apply_vec("t6.rd0", '{1'b1, 1'b0, 30'h140, 32'h0, 1'b0, 32'h12345678});
    apply_vec("t6.rd1", '{1'b1, 1'b0, 30'h141, 32'h0, 1'b0, 32'hF1F1F1F1});
    run_miss("t6c", 1'b1, 1'b0, 30'h000, 32'h0, 1'b1, 28'h50,
             128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_12345678, 1,
             28'h0, 1, 128'h99999999_88888888_CAFEF00D_0BADC0DE, 32'h0BADC0DE);

    @(negedge clk);
    proc_read = 1'b0; proc_write = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
